// File: rtl/vram_write_arbiter.sv
// Round-robin burst arbiter sharing the frame RAM write port among render requesters.
// One grant at a time; accepted words reach the RAM one cycle after the valid/ready handshake.
module vram_write_arbiter #(
  parameter int NREQ       = 4,
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 64,
  parameter int BLANK_ONLY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blank,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [DW-1:0]             wr_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;
  logic            wr_en_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic [DW-1:0]   wr_data_reg;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];
  logic [GW:0]     cand_sum [NREQ];
  logic [GW-1:0]   cand_id  [NREQ];

  logic            open;
  logic            gnt_valid;
  logic            gnt_last;
  logic            xfer;
  logic            at_limit;
  logic            burst_end;
  logic [GW-1:0]   ptr_after;
  logic            pick_found;
  logic [GW-1:0]   pick_id;

  // Candidate k is the requester k positions after the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (GW+1)'(gi);
      assign cand_id[gi]  = (cand_sum[gi] >= (GW+1)'(NREQ)) ?
                            GW'(cand_sum[gi] - (GW+1)'(NREQ)) : GW'(cand_sum[gi]);
    end
  endgenerate

  assign open      = enable & ((BLANK_ONLY != 0) ? blank : 1'b1);
  assign gnt_valid = req_valid[grant_reg];
  assign gnt_last  = req_last[grant_reg];
  assign xfer      = (state_reg == BURST) & open & gnt_valid;
  assign at_limit  = (burst_cnt_reg == CW'(MAX_BURST - 1));
  assign burst_end = (state_reg == BURST) & open & (~gnt_valid | gnt_last | at_limit);
  assign ptr_after = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

  // Scan from the farthest candidate down so the nearest valid one wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr_reg;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[cand_id[k]]) begin
        pick_found = 1'b1;
        pick_id    = cand_id[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (open && pick_found) begin
          state_next     = BURST;
          grant_next     = pick_id;
          burst_cnt_next = '0;
        end
      end
      BURST: begin
        if (xfer) burst_cnt_next = burst_cnt_reg + 1'b1;
        if (burst_end) begin
          state_next  = IDLE;
          rr_ptr_next = ptr_after;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == BURST && open) req_ready[grant_reg] = req_valid[grant_reg];
    busy = (state_reg == BURST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= xfer;
      if (xfer) begin
        wr_addr_reg <= addr_arr[grant_reg];
        wr_data_reg <= data_arr[grant_reg];
      end
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed vector table, scripted corner sequences and
// randomized requesters checked every cycle against a transaction-level reference model.
module tb_vram_write_arbiter;

  localparam int NREQ = 4;
  localparam int MB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        blank = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [63:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  vram_write_arbiter #(.NREQ(NREQ), .AW(16), .DW(8), .MAX_BURST(MB), .BLANK_ONLY(1)) dut (
    .clk(clk), .rst(rst), .blank(blank), .enable(enable),
    .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  // Reference model: one grant holder, a pointer and a word count per burst.
  int         m_busy, m_gid, m_ptr, m_words;
  logic       m_wen;
  logic [15:0] m_waddr;
  logic [7:0]  m_wdata;
  logic [3:0]  m_xfer;

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_words = 0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_xfer = '0;
  endtask

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = '0;
    if (m_busy == 1 && enable && blank && req_valid[m_gid]) r[m_gid] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    bit open;
    bit xf;
    open = enable && blank;
    xf = (m_busy == 1) && open && req_valid[m_gid];
    m_xfer = '0;
    m_wen = xf;
    if (xf) begin
      m_xfer[m_gid] = 1'b1;
      m_waddr = req_addr[m_gid*16 +: 16];
      m_wdata = req_data[m_gid*8 +: 8];
    end
    if (m_busy == 0) begin
      if (open && req_valid != 0) begin
        for (int j = 0; j < NREQ; j++) begin
          if (req_valid[(m_ptr + j) % NREQ]) begin
            m_gid = (m_ptr + j) % NREQ;
            break;
          end
        end
        m_busy = 1;
        m_words = 0;
      end
    end else if (open) begin
      if (xf) m_words++;
      if (!xf || req_last[m_gid] || m_words == MB) begin
        m_busy = 0;
        m_ptr = (m_gid + 1) % NREQ;
      end
    end
  endtask

  // Stimulus sources: word k of requester i has address i*4096+k.
  int src_on[NREQ], src_len[NREQ], src_pos[NREQ], src_left[NREQ];
  int cyc = 0;
  int blank_mode = 0;
  bit en_rand = 0;

  task automatic sources_off();
    for (int i = 0; i < NREQ; i++) begin
      src_on[i] = 0; src_len[i] = 0; src_left[i] = -1;
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (src_on[i] != 0) && (src_left[i] != 0);
      req_addr[i*16 +: 16] = 16'(i*4096 + src_pos[i]);
      req_data[i*8 +: 8] = 8'(i*37 + src_pos[i]*5);
      req_last[i] = (src_len[i] != 0) && (src_pos[i] % src_len[i] == src_len[i] - 1);
    end
    case (blank_mode)
      0: blank = 1'b1;
      1: blank = (cyc % 8) < 3;
      default: blank = ($urandom_range(0, 3) != 0);
    endcase
    enable = en_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
  endtask

  int obs_cnt[16], obs_next[16];
  int order_err, viol, run_id, run_len, max_run;

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) begin
      obs_cnt[i] = 0;
      obs_next[i] = (i < NREQ) ? src_pos[i] : 0;
    end
    order_err = 0; viol = 0; run_id = -1; run_len = 0; max_run = 0;
  endtask

  task automatic observe();
    int id;
    if (wr_en) begin
      id = int'(wr_addr[15:12]);
      obs_cnt[id]++;
      if (int'(wr_addr[11:0]) != obs_next[id]) order_err++;
      obs_next[id] = int'(wr_addr[11:0]) + 1;
      if (id == run_id) run_len++;
      else begin
        run_id = id;
        run_len = 1;
      end
      if (run_len > max_run) max_run = run_len;
    end
    if (((req_valid & req_ready) != 0) && !blank) viol++;
  endtask

  task automatic tick();
    logic [3:0] exp_r;
    @(negedge clk);
    drive_sources();
    #1;
    exp_r = model_ready();
    chk("ready", 64'(req_ready), 64'(exp_r));
    chk("wr", 64'({wr_en, wr_addr, wr_data}), 64'({m_wen, m_waddr, m_wdata}));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    observe();
    model_step();
    for (int i = 0; i < NREQ; i++) begin
      if (m_xfer[i]) begin
        src_pos[i]++;
        if (src_left[i] > 0) src_left[i]--;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    sources_off();
    blank_mode = 0;
    en_rand = 0;
    repeat (6) tick();
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        blk;
    logic        en;
    logic [3:0]  e_ready;
    logic        e_wen;
    logic [15:0] e_waddr;
    logic [7:0]  e_wdata;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{4'b0010, 4'b0000, 16'h0010, 8'hE0, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0000, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b0010, 4'b0000, 16'h0010, 8'hE0, 1'b1, 1'b1, 4'b0010, 1'b0, 16'h0000, 8'h00, 1'b1, 2'd1};
    tbl[2]  = '{4'b0010, 4'b0000, 16'h0011, 8'h1C, 1'b1, 1'b1, 4'b0010, 1'b1, 16'h0010, 8'hE0, 1'b1, 2'd1};
    tbl[3]  = '{4'b0010, 4'b0010, 16'h0012, 8'h03, 1'b1, 1'b1, 4'b0010, 1'b1, 16'h0011, 8'h1C, 1'b1, 2'd1};
    tbl[4]  = '{4'b0000, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h0012, 8'h03, 1'b0, 2'd1};
    tbl[5]  = '{4'b0110, 4'b0110, 16'h0020, 8'h55, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0012, 8'h03, 1'b0, 2'd1};
    tbl[6]  = '{4'b0110, 4'b0110, 16'h0020, 8'h55, 1'b1, 1'b1, 4'b0100, 1'b0, 16'h0012, 8'h03, 1'b1, 2'd2};
    tbl[7]  = '{4'b0010, 4'b0010, 16'h0021, 8'h66, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h0020, 8'h55, 1'b0, 2'd2};
    tbl[8]  = '{4'b0010, 4'b0010, 16'h0021, 8'h66, 1'b1, 1'b1, 4'b0010, 1'b0, 16'h0020, 8'h55, 1'b1, 2'd1};
    tbl[9]  = '{4'b0000, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h0021, 8'h66, 1'b0, 2'd1};
    tbl[10] = '{4'b0001, 4'b0001, 16'h0030, 8'h77, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0021, 8'h66, 1'b0, 2'd1};
    tbl[11] = '{4'b0001, 4'b0001, 16'h0030, 8'h77, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0021, 8'h66, 1'b0, 2'd1};
    tbl[12] = '{4'b0001, 4'b0001, 16'h0030, 8'h77, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0021, 8'h66, 1'b0, 2'd1};
    tbl[13] = '{4'b0001, 4'b0001, 16'h0030, 8'h77, 1'b1, 1'b1, 4'b0001, 1'b0, 16'h0021, 8'h66, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h0030, 8'h77, 1'b0, 2'd0};
    tbl[15] = '{4'b0100, 4'b0100, 16'h0040, 8'h88, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0030, 8'h77, 1'b0, 2'd0};
    tbl[16] = '{4'b0100, 4'b0100, 16'h0040, 8'h88, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0030, 8'h77, 1'b0, 2'd0};
    tbl[17] = '{4'b0100, 4'b0100, 16'h0040, 8'h88, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0030, 8'h77, 1'b1, 2'd2};
    tbl[18] = '{4'b0100, 4'b0100, 16'h0040, 8'h88, 1'b1, 1'b1, 4'b0100, 1'b0, 16'h0030, 8'h77, 1'b1, 2'd2};
    tbl[19] = '{4'b0000, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h0040, 8'h88, 1'b0, 2'd2};

    sources_off();
    for (int i = 0; i < NREQ; i++) src_pos[i] = 0;
    model_reset();

    // Reset state
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr", 64'({wr_addr, wr_data}), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table, starting from the post-reset state
    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid;
      req_last  = tbl[v].last;
      req_addr  = {4{tbl[v].addr}};
      req_data  = {4{tbl[v].data}};
      blank     = tbl[v].blk;
      enable    = tbl[v].en;
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(tbl[v].e_ready));
      chk($sformatf("vec%0d_wr", v), 64'({wr_en, wr_addr, wr_data}),
          64'({tbl[v].e_wen, tbl[v].e_waddr, tbl[v].e_wdata}));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(tbl[v].e_busy));
      chk($sformatf("vec%0d_gid", v), 64'(grant_id), 64'(tbl[v].e_gid));
      model_step();
      cyc++;
    end
    drain();

    // Round-robin: every requester streams two-word bursts
    clear_obs();
    for (int i = 0; i < NREQ; i++) begin
      src_on[i] = 1; src_len[i] = 2;
    end
    repeat (30) tick();
    drain();
    chk("rr_max_run", 64'(max_run), 64'(2));
    chk("rr_order", 64'(order_err), 64'(0));

    // Forced rotation at the burst limit
    clear_obs();
    src_on[0] = 1; src_on[3] = 1;
    repeat (40) tick();
    drain();
    chk("rot_max_run", 64'(max_run), 64'(MB));
    chk("rot_both", 64'((obs_cnt[0] >= MB) && (obs_cnt[3] >= MB)), 64'(1));

    // Blank gating: 3 cycles open, 5 closed
    clear_obs();
    blank_mode = 1;
    src_on[2] = 1; src_left[2] = 10;
    repeat (150) tick();
    drain();
    chk("blank_words", 64'(obs_cnt[2]), 64'(10));
    chk("blank_order", 64'(order_err), 64'(0));
    chk("blank_viol", 64'(viol), 64'(0));

    // Abandon after two words
    clear_obs();
    src_on[1] = 1; src_left[1] = 2;
    repeat (10) tick();
    drain();
    chk("abandon_words", 64'(obs_cnt[1]), 64'(2));

    // Reset mid-burst
    src_on[2] = 1;
    repeat (4) tick();
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_grant", 64'(grant_id), 64'(0));
    sources_off();
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    src_on[1] = 1; src_len[1] = 2;
    src_on[2] = 1; src_len[2] = 2;
    repeat (2) tick();
    chk("midrst_next_grant", 64'(grant_id), 64'(1));
    drain();

    // Randomized requesters, blanking and enable
    blank_mode = 2;
    en_rand = 1;
    for (int i = 0; i < NREQ; i++) begin
      src_on[i] = int'($urandom_range(0, 1));
      src_len[i] = int'($urandom_range(0, 5));
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 15) == 0) src_on[i] = (src_on[i] != 0) ? 0 : 1;
      end
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
